// File: rtl/rh_dma_seq_if.sv
// rtl/rh_dma_seq_if.sv - signal bundle between the RH11 register file, data buffer, bus arbiter and the DMA sequencer
interface rh_dma_seq_if;
    logic        devRESET;
    logic        rhCLR;
    logic        rhGO;
    logic        rhSTOP;
    logic        rhDIR;
    logic [15:0] rhWC;
    logic        fifoEMPTY;
    logic        fifoFULL;
    logic        devACKI;
    logic        devREQO;
    logic        devREADO;
    logic        fifoRD;
    logic        fifoWR;
    logic        rhINCWC;
    logic        rhINCBA;
    logic        rhBUSY;
    logic        rhDONE;
    logic        rhNXM;

    modport master (
        input  devRESET, rhCLR, rhGO, rhSTOP, rhDIR, rhWC,
        input  fifoEMPTY, fifoFULL, devACKI,
        output devREQO, devREADO, fifoRD, fifoWR,
        output rhINCWC, rhINCBA, rhBUSY, rhDONE, rhNXM
    );

    modport slave (
        output devRESET, rhCLR, rhGO, rhSTOP, rhDIR, rhWC,
        output fifoEMPTY, fifoFULL, devACKI,
        input  devREQO, devREADO, fifoRD, fifoWR,
        input  rhINCWC, rhINCBA, rhBUSY, rhDONE, rhNXM
    );
endinterface

// File: rtl/rh_dma_seq.sv
// rtl/rh_dma_seq.sv - RH11 DMA transfer sequencer: one 36-bit word per KS10 bus cycle
module rh_dma_seq #(
    parameter int TIMEOUT = 127
) (
    input  logic       clk,
    input  logic       rst,
    rh_dma_seq_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_REQ,
        S_INC,
        S_DONE
    } state_t;

    state_t     r_state;
    logic       r_dir;
    logic [6:0] r_cnt;
    logic       r_req;
    logic       r_read;
    logic       r_incwc;
    logic       r_incba;
    logic       r_busy;
    logic       r_done;
    logic       r_nxm;

    logic w_abort;
    logic w_ready;
    logic w_last;
    logic w_take;
    logic w_expire;

    assign w_abort  = bus.devRESET | bus.rhCLR;
    assign w_ready  = r_dir ? !bus.fifoFULL : !bus.fifoEMPTY;
    assign w_last   = (bus.rhWC == 16'hFFFE);
    assign w_expire = (r_cnt == 7'(TIMEOUT - 1));
    // The buffer strobe must coincide with the ack cycle, so it cannot wait for a register.
    assign w_take   = (r_state == S_REQ) && bus.devACKI && !w_abort;

    always_ff @(posedge clk) begin
        if (rst || w_abort) begin
            r_state <= S_IDLE;
            r_dir   <= 1'b0;
            r_cnt   <= 7'd0;
            r_req   <= 1'b0;
            r_read  <= 1'b0;
            r_incwc <= 1'b0;
            r_incba <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_nxm   <= 1'b0;
        end else begin
            r_incwc <= 1'b0;
            r_incba <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.rhGO) begin
                        r_dir   <= bus.rhDIR;
                        r_nxm   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.rhSTOP) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else if (w_ready) begin
                        r_req   <= 1'b1;
                        r_read  <= r_dir;
                        r_cnt   <= 7'd0;
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    // Ack is tested first so an ack on the final timeout cycle still completes the word.
                    if (bus.devACKI) begin
                        r_req   <= 1'b0;
                        r_read  <= 1'b0;
                        r_cnt   <= 7'd0;
                        r_incwc <= 1'b1;
                        r_incba <= 1'b1;
                        r_state <= S_INC;
                    end else if (w_expire) begin
                        r_req   <= 1'b0;
                        r_read  <= 1'b0;
                        r_cnt   <= 7'd0;
                        r_nxm   <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 7'd1;
                    end
                end
                S_INC: begin
                    if (w_last || bus.rhSTOP) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.devREQO  = r_req;
    assign bus.devREADO = r_read;
    assign bus.fifoRD   = w_take & !r_dir;
    assign bus.fifoWR   = w_take & r_dir;
    assign bus.rhINCWC  = r_incwc;
    assign bus.rhINCBA  = r_incba;
    assign bus.rhBUSY   = r_busy;
    assign bus.rhDONE   = r_done;
    assign bus.rhNXM    = r_nxm;
endmodule

// File: tb/tb_rh_dma_seq.sv
// tb/tb_rh_dma_seq.sv - directed and randomized checks of rh_dma_seq against a word-count/bus-cycle model
module tb_rh_dma_seq;
    localparam int TMO = 127;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rh_dma_seq_if bus();
    rh_dma_seq #(.TIMEOUT(TMO)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int failures = 0;

    logic [15:0] wc;
    bit pending_inc, ack_en, rand_delay, rand_fifo, prev_req, cur_dir;
    int cyc, n_rd, n_wr, n_incwc, n_incba, n_done, n_req_cyc, n_req_start;
    int done_cyc, read_viol, ack_delay, max_delay, req_age;

    function automatic int words_for(input logic [15:0] w);
        return (w == 16'h0000) ? 32768 : (65536 - int'(w)) / 2;
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
        end
    endtask

    task automatic clr_cnt();
        n_rd = 0; n_wr = 0; n_incwc = 0; n_incba = 0; n_done = 0;
        n_req_cyc = 0; n_req_start = 0; done_cyc = -1; read_viol = 0;
    endtask

    // Environment: models the word-count register, the arbiter ack and the buffer flags.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (pending_inc) wc = wc + 16'd2;
        pending_inc = 1'b0;
        bus.rhWC = wc;
        if (bus.rhINCWC === 1'b1) begin n_incwc++; pending_inc = 1'b1; end
        if (bus.rhINCBA === 1'b1) n_incba++;
        if (bus.rhDONE === 1'b1) begin n_done++; done_cyc = cyc; end
        if (bus.devREQO === 1'b1) begin
            n_req_cyc++;
            if (!prev_req) n_req_start++;
            if (bus.devREADO !== cur_dir) read_viol++;
        end
        prev_req = (bus.devREQO === 1'b1);
        if (bus.devREQO === 1'b1 && ack_en) begin
            bus.devACKI = (req_age == ack_delay);
            req_age++;
        end else begin
            bus.devACKI = 1'b0;
            req_age = 0;
            if (rand_delay) ack_delay = $urandom_range(0, max_delay);
        end
        if (rand_fifo) begin
            bus.fifoEMPTY = ($urandom_range(0, 2) == 0);
            bus.fifoFULL  = ($urandom_range(0, 2) == 0);
        end
        #3;
        if (bus.fifoRD === 1'b1) n_rd++;
        if (bus.fifoWR === 1'b1) n_wr++;
    endtask

    task automatic start(input logic [15:0] w, input logic d);
        wc = w;
        bus.rhWC = w;
        bus.rhDIR = d;
        cur_dir = d;
        clr_cnt();
        bus.rhGO = 1'b1;
        step();
        bus.rhGO = 1'b0;
    endtask

    task automatic run_done(input string name, input int budget);
        int k = 0;
        while (n_done == 0 && k < budget) begin
            step();
            k++;
        end
        chk({name, "_finished"}, 32'(n_done != 0), 32'd1);
        step();
    endtask

    task automatic check_xfer(input string name, input int exp_words);
        chk({name, "_fifo_pops"},  n_rd, cur_dir ? 0 : exp_words);
        chk({name, "_fifo_push"},  n_wr, cur_dir ? exp_words : 0);
        chk({name, "_incwc"},      n_incwc, exp_words);
        chk({name, "_incba"},      n_incba, exp_words);
        chk({name, "_done"},       n_done, 1);
        chk({name, "_nxm"},        32'(bus.rhNXM), 0);
        chk({name, "_readdir"},    read_viol, 0);
        chk({name, "_busy_after"}, 32'(bus.rhBUSY), 0);
    endtask

    initial begin
        logic [15:0] wcv;
        int w, fall, k;
        bit d;
        cyc = 0; pending_inc = 0; prev_req = 0; req_age = 0;
        ack_en = 1; rand_delay = 0; rand_fifo = 0; ack_delay = 0; max_delay = 0;
        cur_dir = 0; wc = 16'h0;
        bus.devRESET = 0; bus.rhCLR = 0; bus.rhGO = 1; bus.rhSTOP = 0; bus.rhDIR = 1;
        bus.rhWC = 16'h0; bus.fifoEMPTY = 0; bus.fifoFULL = 0; bus.devACKI = 0;
        rst = 1;
        clr_cnt();
        repeat (3) step();
        chk("rst_busy", 32'(bus.rhBUSY), 0);
        chk("rst_req",  32'(bus.devREQO), 0);
        chk("rst_nxm",  32'(bus.rhNXM), 0);
        chk("rst_done", 32'(bus.rhDONE), 0);
        chk("rst_inc",  32'(bus.rhINCWC), 0);
        rst = 0;
        bus.rhGO = 0;
        step();

        // Three-word device-to-memory transfer, ack one cycle after request.
        ack_delay = 1;
        start(16'hFFFA, 1'b0);
        run_done("t1", 200);
        check_xfer("t1", words_for(16'hFFFA));

        // Randomized lengths, directions, ack latencies and buffer flags.
        for (int i = 0; i < 6; i++) begin
            w = $urandom_range(1, 8);
            wcv = 16'(65536 - 2 * w);
            d = 1'($urandom_range(0, 1));
            rand_delay = 1; max_delay = 4; rand_fifo = 1;
            start(wcv, d);
            run_done($sformatf("rnd%0d", i), 600);
            rand_fifo = 0; bus.fifoEMPTY = 0; bus.fifoFULL = 0;
            check_xfer($sformatf("rnd%0d", i), words_for(wcv));
        end
        rand_delay = 0;

        // Single word, buffer full holds off the request.
        ack_delay = 0;
        bus.fifoFULL = 1;
        start(16'hFFFE, 1'b1);
        repeat (10) step();
        chk("t2_req_while_full", n_req_cyc, 0);
        bus.fifoFULL = 0;
        fall = cyc;
        run_done("t2", 50);
        chk("t2_done_latency", done_cyc - fall, 3);
        check_xfer("t2", 1);

        // No ack: NXM after the full timeout.
        ack_en = 0;
        start(16'hFFF0, 1'b0);
        run_done("t3", 400);
        chk("t3_req_cycles", n_req_cyc, TMO);
        chk("t3_nxm", 32'(bus.rhNXM), 1);
        chk("t3_done", n_done, 1);
        chk("t3_incwc", n_incwc, 0);
        chk("t3_pops", n_rd, 0);
        ack_en = 1;
        ack_delay = 0;
        start(16'hFFFE, 1'b0);
        chk("t3_go_clears_nxm", 32'(bus.rhNXM), 0);
        run_done("t3b", 50);
        check_xfer("t3b", 1);

        // Ack on the last timeout cycle beats the expiry.
        ack_delay = TMO - 1;
        start(16'hFFFE, 1'b1);
        run_done("t3c", 400);
        chk("t3c_req_cycles", n_req_cyc, TMO);
        check_xfer("t3c", 1);

        // Stop during a request: the current word completes, nothing further.
        ack_delay = 2;
        start(16'hFFF8, 1'b0);
        k = 0;
        while (bus.devREQO !== 1'b1 && k < 20) begin step(); k++; end
        chk("t4_req_seen", 32'(bus.devREQO), 1);
        bus.rhSTOP = 1;
        run_done("t4", 50);
        bus.rhSTOP = 0;
        chk("t4_req_starts", n_req_start, 1);
        check_xfer("t4", 1);

        // Controller clear during the second word's request.
        ack_delay = 5;
        start(16'hFFF0, 1'b0);
        k = 0;
        while (!(n_incwc == 1 && bus.devREQO === 1'b1) && k < 50) begin step(); k++; end
        chk("t5_second_req", 32'(bus.devREQO), 1);
        bus.rhCLR = 1;
        step();
        bus.rhCLR = 0;
        chk("t5_req_dropped", 32'(bus.devREQO), 0);
        chk("t5_busy_dropped", 32'(bus.rhBUSY), 0);
        repeat (5) step();
        chk("t5_no_done", n_done, 0);
        chk("t5_incwc", n_incwc, 1);
        ack_delay = 0;
        start(16'hFFFC, 1'b0);
        run_done("t5b", 50);
        check_xfer("t5b", 2);

        // Device reset while waiting on a full buffer.
        bus.fifoFULL = 1;
        start(16'hFFF0, 1'b1);
        repeat (3) step();
        bus.devRESET = 1;
        step();
        bus.devRESET = 0;
        bus.fifoFULL = 0;
        chk("t5c_busy", 32'(bus.rhBUSY), 0);
        repeat (4) step();
        chk("t5c_no_req", n_req_cyc, 0);
        chk("t5c_no_done", n_done, 0);

        // Zero word count runs on (full wrap); GO while busy is ignored.
        rand_delay = 1; max_delay = 1;
        start(16'h0000, 1'b1);
        k = 0;
        while (n_incwc < 300 && k < 3000) begin
            step();
            k++;
            if (k % 37 == 0) begin bus.rhGO = 1; bus.rhDIR = 0; end
            else begin bus.rhGO = 0; bus.rhDIR = 1; end
        end
        bus.rhGO = 0; bus.rhDIR = 1;
        chk("t6_words", n_incwc, 300);
        chk("t6_no_done", n_done, 0);
        chk("t6_busy", 32'(bus.rhBUSY), 1);
        chk("t6_dir_held", read_viol, 0);
        bus.rhSTOP = 1;
        run_done("t6", 50);
        bus.rhSTOP = 0;
        chk("t6_push_eq_inc", n_wr, n_incwc);
        chk("t6_done", n_done, 1);
        chk("t6_nxm", 32'(bus.rhNXM), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rh_dma_seq.md
Name: rh_dma_seq

Overview:
RH11 DMA transfer sequencer. It consumes the word count and bus address registers: it moves one 36-bit word per bus cycle between the RH11 data buffer and KS10 memory. After each completed transfer it pulses rhINCWC and rhINCBA. It terminates when the word count overflows to zero, on abort, or on a non-existent-memory (NXM) timeout. It sits between the RH11 register file and the KS10 bus arbiter.

Parameters:
TIMEOUT, 127, maximum cycles to wait for devACKI before declaring NXM (7-bit counter).

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
devRESET  input  1  device reset; aborts to IDLE, no done pulse
rhCLR  input  1  controller clear; same effect as devRESET
rhGO  input  1  one-cycle start pulse; ignored unless IDLE
rhSTOP  input  1  abort request from drive/controller
rhDIR  input  1  1 = memory-to-device (bus read); 0 = device-to-memory (bus write); sampled at GO
rhWC  input  16  current word count (two's complement, advances by 2 per word)
fifoEMPTY  input  1  data buffer empty
fifoFULL  input  1  data buffer full
devACKI  input  1  bus acknowledge from arbiter
devREQO  output  1  bus request
devREADO  output  1  1 = read memory cycle, 0 = write memory cycle
fifoRD  output  1  one-cycle pop of data buffer (bus write path)
fifoWR  output  1  one-cycle push into data buffer (bus read path)
rhINCWC  output  1  one-cycle word count increment strobe
rhINCBA  output  1  one-cycle bus address increment strobe
rhBUSY  output  1  transfer in progress
rhDONE  output  1  one-cycle completion pulse
rhNXM  output  1  sticky NXM error; cleared by GO, devRESET, rhCLR

Behaviour:
- Reset values (rst, devRESET, rhCLR): all outputs 0, state IDLE, timeout counter 0, latched direction 0. rst has priority over all other inputs.
- States: IDLE, WAIT, REQ, INC, DONE.
- IDLE: on rhGO, latch rhDIR, clear rhNXM, go to WAIT. rhBUSY=1 in every state except IDLE.
- WAIT: when the buffer is ready, go to REQ. Ready means (dir=1 and !fifoFULL) or (dir=0 and !fifoEMPTY). If rhSTOP, go to DONE instead.
- REQ:
  - devREQO=1; devREADO equals the latched direction. Both are held stable until ack.
  - Timeout counter increments each cycle.
  - On devACKI: pulse fifoWR (dir=1) or fifoRD (dir=0) in that same cycle, clear the counter, go to INC.
  - If the counter reaches TIMEOUT without ack: set rhNXM, drop devREQO, go to DONE.
  - rhSTOP does not abort an outstanding request.
- INC:
  - Pulse rhINCWC and rhINCBA for exactly one cycle.
  - Last word means rhWC == 16'hFFFE, sampled in INC before the register updates.
  - If last word or rhSTOP: go to DONE. Otherwise go to WAIT.
- DONE: rhDONE=1 for one cycle, then IDLE.
- rhWC == 0 at GO means 32768 words (full wrap). No early exit at start.
- Worst-case latency per word with buffer ready and immediate ack: WAIT, REQ, INC = 3 cycles.
- GO while busy is ignored. devRESET/rhCLR mid-transfer go immediately to IDLE: no INC, no DONE, devREQO drops the next cycle.
- Simultaneous devACKI and timeout expiry: ack wins.

Test Plan:
1. rhWC=16'hFFFA, dir=0, fifo non-empty, ack one cycle after request -> exactly 3 transfers; 3 fifoRD, 3 rhINCWC, 3 rhINCBA pulses; 1 rhDONE; rhNXM=0; devREADO=0 throughout.
2. rhWC=16'hFFFE, dir=1, fifoFULL high for 10 cycles then low -> devREQO stays 0 while full; 1 fifoWR; rhDONE 3 cycles after fifoFULL falls.
3. devACKI never asserted -> devREQO high for TIMEOUT=127 cycles; rhNXM=1; rhDONE pulses; rhINCWC never pulses; next rhGO clears rhNXM.
4. rhSTOP asserted during REQ with a 4-word count -> current word completes (1 rhINCWC), then DONE; no further devREQO.
5. rhCLR during REQ of a multi-word transfer -> next cycle devREQO=0, rhBUSY=0, no rhDONE; second rhGO restarts normally.
6. rhWC=0 at GO, model increments WC by 2 per word -> 32768 rhINCWC pulses before rhDONE; rhGO pulses while busy have no effect.
